// File: rtl/number_grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : number_grid_pkg
// Description : Shared types and helpers for the number grid display:
//               per-cell visibility states, cell placement and cell colour.
// Revision    : 1.0 - initial release
// ============================================================================
package number_grid_pkg;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    HIDE  = 2'd1,
    BLINK = 2'd2
  } cell_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } cell_pos_t;

  // Glyph box of one rendered digit, in pixels
  localparam int c_CELL_W = 16;
  localparam int c_CELL_H = 32;

  // Column-major placement: index walks down a column before moving right
  function automatic cell_pos_t cell_pos(input int i, input int rows,
                                         input int tlx, input int tly,
                                         input int xd, input int yd);
    cell_pos_t p;
    p.x = 11'(tlx + xd * (i / rows));
    p.y = 11'(tly + yd * (i % rows));
    return p;
  endfunction

  // Distinct colour per cell so overlapping cells can be told apart
  function automatic logic [7:0] cell_color(input int i);
    return 8'h1F | 8'((i % 8) << 5);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/number_cell_timer.sv
`default_nettype none
// ============================================================================
// Module      : number_cell_timer
// Description : Hit-driven visibility FSM for one grid cell with a
//               frame-counting timer, registered show, expiry and busy bits.
// Revision    : 1.0 - initial release
// ============================================================================
module number_cell_timer
  import number_grid_pkg::*;
#(
  parameter int HIDE_FRAMES  = 450,
  parameter int BLINK_FRAMES = 0,
  parameter int BLINK_LOG2   = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic hit_i,
  input  logic tick_i,      // frame boundary while not frozen
  output logic show_o,
  output logic expired_o,
  output logic busy_o
);

  localparam int T_W = $clog2(max_int(HIDE_FRAMES, BLINK_FRAMES) + 1);
  localparam logic [T_W-1:0] c_HIDE  = T_W'(HIDE_FRAMES);
  localparam logic [T_W-1:0] c_BLINK = T_W'(BLINK_FRAMES);
  localparam logic [T_W-1:0] c_ONE   = T_W'(1);

  cell_state_t    state_q;
  logic [T_W-1:0] timer_q;
  logic           show_q;
  logic           expired_q;
  logic           busy_q;
  logic           w_blink_off;

  // Blink phase bit, widened so a large BLINK_LOG2 simply reads as zero
  assign w_blink_off = ((32'(timer_q) >> BLINK_LOG2) & 32'd1) != 32'd0;

  // Cell FSM: hits always win over a coincident frame tick
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= SHOW;
      timer_q   <= '0;
      show_q    <= 1'b1;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      show_q    <= (state_q == SHOW) | ((state_q == BLINK) & ~w_blink_off);
      if (hit_i) begin
        state_q <= HIDE;
        timer_q <= c_HIDE;
        busy_q  <= 1'b1;
      end else if (tick_i) begin
        case (state_q)
          HIDE: begin
            if (timer_q == c_ONE) begin
              if (BLINK_FRAMES > 0) begin
                state_q <= BLINK;
                timer_q <= c_BLINK;
              end else begin
                state_q   <= SHOW;
                timer_q   <= '0;
                expired_q <= 1'b1;
                busy_q    <= 1'b0;
              end
            end else begin
              timer_q <= timer_q - c_ONE;
            end
          end
          BLINK: begin
            if (timer_q == c_ONE) begin
              state_q   <= SHOW;
              timer_q   <= '0;
              expired_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              timer_q <= timer_q - c_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign show_o    = show_q;
  assign expired_o = expired_q;
  assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: rtl/number_display.sv
`default_nettype none
// ============================================================================
// Module      : number_display
// Description : Seven-segment style renderer for one digit in a 16x32 box.
//               Purely combinational from the pixel position.
// Revision    : 1.0 - initial release
// ============================================================================
module number_display
  import number_grid_pkg::*;
#(
  parameter logic [7:0] COLOR = 8'hFF
) (
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic [3:0]  digit,
  input  logic        show,
  output logic        drawingRequest,
  output logic [7:0]  RGBout
);

  logic        w_in_box;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [6:0]  w_seg;   // {a,b,c,d,e,f,g}
  logic        w_lit;

  assign w_in_box = ({1'b0, pixelX} >= {1'b0, topLeftX}) &&
                    ({1'b0, pixelX} <  {1'b0, topLeftX} + 12'(c_CELL_W)) &&
                    ({1'b0, pixelY} >= {1'b0, topLeftY}) &&
                    ({1'b0, pixelY} <  {1'b0, topLeftY} + 12'(c_CELL_H));
  assign w_dx = pixelX - topLeftX;
  assign w_dy = pixelY - topLeftY;

  // Segment pattern per digit; values above 9 draw nothing
  always_comb begin
    w_seg = 7'b0000000;
    case (digit)
      4'd0: w_seg = 7'b1111110;
      4'd1: w_seg = 7'b0110000;
      4'd2: w_seg = 7'b1101101;
      4'd3: w_seg = 7'b1111001;
      4'd4: w_seg = 7'b0110011;
      4'd5: w_seg = 7'b1011011;
      4'd6: w_seg = 7'b1011111;
      4'd7: w_seg = 7'b1110000;
      4'd8: w_seg = 7'b1111111;
      4'd9: w_seg = 7'b1111011;
      default: w_seg = 7'b0000000;
    endcase
  end

  // Map the in-box offset onto the lit segments
  always_comb begin
    w_lit = 1'b0;
    if (w_seg[6] && w_dy <= 11'd3  && w_dx >= 11'd2  && w_dx <= 11'd13) w_lit = 1'b1;
    if (w_seg[5] && w_dx >= 11'd12 && w_dy >= 11'd2  && w_dy <= 11'd15) w_lit = 1'b1;
    if (w_seg[4] && w_dx >= 11'd12 && w_dy >= 11'd16 && w_dy <= 11'd29) w_lit = 1'b1;
    if (w_seg[3] && w_dy >= 11'd28 && w_dx >= 11'd2  && w_dx <= 11'd13) w_lit = 1'b1;
    if (w_seg[2] && w_dx <= 11'd3  && w_dy >= 11'd16 && w_dy <= 11'd29) w_lit = 1'b1;
    if (w_seg[1] && w_dx <= 11'd3  && w_dy >= 11'd2  && w_dy <= 11'd15) w_lit = 1'b1;
    if (w_seg[0] && w_dy >= 11'd14 && w_dy <= 11'd17 && w_dx >= 11'd2 && w_dx <= 11'd13) w_lit = 1'b1;
  end

  assign drawingRequest = w_in_box & w_lit & show;
  assign RGBout         = COLOR;

endmodule
`default_nettype wire

// File: rtl/number_grid_display.sv
`default_nettype none
// ============================================================================
// Module      : number_grid_display
// Description : ROWS x COLS grid of digits with per-cell hit/hide/blink
//               timing, priority-merged draw request and colour.
// Revision    : 1.0 - initial release
// ============================================================================
module number_grid_display
  import number_grid_pkg::*;
#(
  parameter int ROWS         = 3,
  parameter int COLS         = 1,
  parameter int TOP_LEFT_X   = 150,
  parameter int TOP_LEFT_Y   = 100,
  parameter int X_DIFF       = 50,
  parameter int Y_DIFF       = 100,
  parameter int HIDE_FRAMES  = 450,
  parameter int BLINK_FRAMES = 0,
  parameter int BLINK_LOG2   = 3,
  localparam int NUM_CELLS   = ROWS * COLS
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_CELLS-1:0][3:0] numbersToShow,
  input  logic [10:0]               pixelX,
  input  logic [10:0]               pixelY,
  input  logic                      startOfFrame,
  input  logic [NUM_CELLS-1:0]      singleHit,
  input  logic                      freeze,
  output logic [NUM_CELLS-1:0]      numbersDR,
  output logic [NUM_CELLS-1:0][7:0] numbersRGB,
  output logic                      anyDR,
  output logic [7:0]                mergedRGB,
  output logic [NUM_CELLS-1:0]      showNum,
  output logic [NUM_CELLS-1:0]      expired,
  output logic                      busy
);

  logic                 w_tick;
  logic [NUM_CELLS-1:0] w_busy;

  assign w_tick = startOfFrame & ~freeze;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    localparam cell_pos_t c_POS = cell_pos(i, ROWS, TOP_LEFT_X, TOP_LEFT_Y, X_DIFF, Y_DIFF);

    number_cell_timer #(
      .HIDE_FRAMES  (HIDE_FRAMES),
      .BLINK_FRAMES (BLINK_FRAMES),
      .BLINK_LOG2   (BLINK_LOG2)
    ) u_timer (
      .clk       (clk),
      .resetN    (resetN),
      .hit_i     (singleHit[i]),
      .tick_i    (w_tick),
      .show_o    (showNum[i]),
      .expired_o (expired[i]),
      .busy_o    (w_busy[i])
    );

    number_display #(
      .COLOR (cell_color(i))
    ) u_display (
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .topLeftX       (c_POS.x),
      .topLeftY       (c_POS.y),
      .digit          (numbersToShow[i]),
      .show           (showNum[i]),
      .drawingRequest (numbersDR[i]),
      .RGBout         (numbersRGB[i])
    );
  end

  assign busy = |w_busy;

  // Fixed-priority merge: walking downward lets index 0 overwrite the rest
  always_comb begin
    anyDR     = 1'b0;
    mergedRGB = 8'h00;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (numbersDR[i]) begin
        anyDR     = 1'b1;
        mergedRGB = numbersRGB[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_number_grid_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_number_grid_display
// Description : Self-checking bench for number_grid_display with two
//               configurations (plain hide, hide+blink) and a frame-count
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_number_grid_display;

  localparam int N    = 6;
  localparam int LOG2 = 3;
  int HF[2] = '{4, 2};
  int BF[2] = '{0, 16};

  logic             clk    = 1'b0;
  logic             resetN = 1'b0;
  logic [N-1:0][3:0] nums  = {N{4'd8}};
  logic [10:0]      pixelX = '0;
  logic [10:0]      pixelY = '0;
  logic             sof    = 1'b0;
  logic             freeze = 1'b0;
  logic [N-1:0]     hitA   = '0;
  logic [N-1:0]     hitB   = '0;

  logic [N-1:0]      drA, drB, showA, showB, expA, expB;
  logic [N-1:0][7:0] rgbA, rgbB;
  logic              anyA, anyB, busyA, busyB;
  logic [7:0]        mrgA, mrgB;

  int total = 0;
  int bad   = 0;

  number_grid_display #(
    .ROWS(3), .COLS(2), .TOP_LEFT_X(150), .TOP_LEFT_Y(100), .X_DIFF(8), .Y_DIFF(100),
    .HIDE_FRAMES(4), .BLINK_FRAMES(0), .BLINK_LOG2(LOG2)
  ) u_dut_a (
    .clk(clk), .resetN(resetN), .numbersToShow(nums), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(sof), .singleHit(hitA), .freeze(freeze), .numbersDR(drA),
    .numbersRGB(rgbA), .anyDR(anyA), .mergedRGB(mrgA), .showNum(showA),
    .expired(expA), .busy(busyA)
  );

  number_grid_display #(
    .ROWS(3), .COLS(2), .TOP_LEFT_X(150), .TOP_LEFT_Y(100), .X_DIFF(50), .Y_DIFF(100),
    .HIDE_FRAMES(2), .BLINK_FRAMES(16), .BLINK_LOG2(LOG2)
  ) u_dut_b (
    .clk(clk), .resetN(resetN), .numbersToShow(nums), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(sof), .singleHit(hitB), .freeze(freeze), .numbersDR(drB),
    .numbersRGB(rgbB), .anyDR(anyB), .mergedRGB(mrgB), .showNum(showB),
    .expired(expB), .busy(busyB)
  );

  always #5 clk = ~clk;

  // Reference model: frames counted since the last hit (-1 = idle/shown)
  int since[2][N];
  bit m_show[2][N];
  bit m_exp[2][N];

  function automatic bit vis(input int d, input int s);
    int t;
    if (s < 0) return 1'b1;
    if (s < HF[d]) return 1'b0;
    t = HF[d] + BF[d] - s;
    return ((t >> LOG2) & 1) == 0;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < N; c++) begin
          since[d][c] = -1; m_show[d][c] = 1'b1; m_exp[d][c] = 1'b0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < N; c++) begin
          m_show[d][c] = vis(d, since[d][c]);
          m_exp[d][c]  = 1'b0;
          if ((d == 0) ? hitA[c] : hitB[c]) since[d][c] = 0;
          else if (since[d][c] >= 0 && sof && !freeze) begin
            since[d][c] = since[d][c] + 1;
            if (since[d][c] == HF[d] + BF[d]) begin
              since[d][c] = -1; m_exp[d][c] = 1'b1;
            end
          end
        end
    end
  end

  task automatic sof_pulse();
    sof = 1'b1; @(negedge clk); sof = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (showA !== 6'h3F) begin bad++; $display("FAIL reset_showA got=%h want=3f", showA); end
    total++; if (showB !== 6'h3F) begin bad++; $display("FAIL reset_showB got=%h want=3f", showB); end
    total++; if (busyA !== 1'b0 || busyB !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", busyA, busyB); end
    total++; if (expA !== '0 || expB !== '0) begin bad++; $display("FAIL reset_expired got=%h/%h want=0", expA, expB); end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_merge();
    pixelX = 11'd160; pixelY = 11'd101; #1;
    total++; if (drA[0] !== 1'b1 || drA[3] !== 1'b1) begin bad++; $display("FAIL merge_overlap_dr got=%b want=both", drA); end
    total++; if (anyA !== 1'b1 || mrgA !== 8'h1F) begin bad++; $display("FAIL merge_priority got=%b/%h want=1/1f", anyA, mrgA); end
    pixelX = 11'd170; #1;
    total++; if (mrgA !== 8'h7F) begin bad++; $display("FAIL merge_cell3_only got=%h want=7f", mrgA); end
    pixelX = 11'd100; pixelY = 11'd50; #1;
    total++; if (anyA !== 1'b0 || mrgA !== 8'h00) begin bad++; $display("FAIL merge_none got=%b/%h want=0/00", anyA, mrgA); end
    hitA = 6'b000001; @(negedge clk); hitA = '0; @(negedge clk);
    pixelX = 11'd160; pixelY = 11'd101; #1;
    total++; if (drA[0] !== 1'b0 || mrgA !== 8'h7F) begin bad++; $display("FAIL merge_hidden0 got=%b/%h want=0/7f", drA[0], mrgA); end
  endtask

  task automatic test_placement();
    pixelX = 11'd205; pixelY = 11'd101; #1;
    total++; if (drB !== 6'b001000) begin bad++; $display("FAIL place_cell3 got=%b want=001000", drB); end
    pixelX = 11'd199; #1;
    total++; if (drB !== 6'b000000) begin bad++; $display("FAIL place_left_of_cell3 got=%b want=000000", drB); end
    pixelX = 11'd155; pixelY = 11'd201; #1;
    total++; if (drB !== 6'b000010) begin bad++; $display("FAIL place_cell1 got=%b want=000010", drB); end
    pixelX = '0; pixelY = '0;
  endtask

  task automatic test_timeout();
    hitA = 6'b000100; @(negedge clk); hitA = '0;
    total++; if (busyA !== 1'b1) begin bad++; $display("FAIL timeout_busy got=%b want=1", busyA); end
    @(negedge clk);
    total++; if (showA[2] !== 1'b0) begin bad++; $display("FAIL timeout_hidden got=%b want=0", showA[2]); end
    for (int k = 1; k <= 4; k++) begin
      sof_pulse();
      total++; if (expA[2] !== (k == 4)) begin bad++; $display("FAIL timeout_expired_f%0d got=%b want=%b", k, expA[2], (k == 4)); end
      if (k < 4) begin
        total++; if (showA[2] !== 1'b0) begin bad++; $display("FAIL timeout_show_f%0d got=%b want=0", k, showA[2]); end
      end
    end
    @(negedge clk);
    total++; if (expA[2] !== 1'b0 || showA[2] !== 1'b1) begin bad++; $display("FAIL timeout_after got=%b/%b want=0/1", expA[2], showA[2]); end
  endtask

  task automatic test_retrigger();
    hitA = 6'b000010; @(negedge clk); hitA = '0;
    repeat (3) sof_pulse();
    hitA = 6'b000010; sof = 1'b1; @(negedge clk); hitA = '0; sof = 1'b0;
    total++; if (expA[1] !== 1'b0) begin bad++; $display("FAIL retrig_coincident got=%b want=0", expA[1]); end
    for (int k = 1; k <= 4; k++) begin
      sof_pulse();
      total++; if (expA[1] !== (k == 4)) begin bad++; $display("FAIL retrig_f%0d got=%b want=%b", k, expA[1], (k == 4)); end
    end
  endtask

  task automatic test_freeze();
    hitA = 6'b010000; @(negedge clk); hitA = '0;
    sof_pulse();
    freeze = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sof_pulse();
      total++; if (expA[4] !== 1'b0) begin bad++; $display("FAIL freeze_hold_f%0d got=%b want=0", k, expA[4]); end
    end
    total++; if (busyA !== 1'b1 || showA[4] !== 1'b0) begin bad++; $display("FAIL freeze_state got=%b/%b want=1/0", busyA, showA[4]); end
    hitA = 6'b010000; @(negedge clk); hitA = '0;
    freeze = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sof_pulse();
      total++; if (expA[4] !== (k == 4)) begin bad++; $display("FAIL freeze_reload_f%0d got=%b want=%b", k, expA[4], (k == 4)); end
    end
  endtask

  task automatic test_blink();
    bit want;
    hitB = 6'b000001; @(negedge clk); hitB = '0;
    for (int k = 1; k <= 18; k++) begin
      sof_pulse();
      total++; if (expB[0] !== (k == 18)) begin bad++; $display("FAIL blink_expired_f%0d got=%b want=%b", k, expB[0], (k == 18)); end
      @(negedge clk);
      want = (k == 2) || (k >= 11);
      total++; if (showB[0] !== want) begin bad++; $display("FAIL blink_show_f%0d got=%b want=%b", k, showB[0], want); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eA, eB, xA, xB;
    bit bA, bB;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        hitA[c] = ($urandom_range(0, 31) == 0);
        hitB[c] = ($urandom_range(0, 31) == 0);
      end
      sof    = ($urandom_range(0, 3) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      bA = 1'b0; bB = 1'b0;
      for (int c = 0; c < N; c++) begin
        eA[c] = m_show[0][c]; eB[c] = m_show[1][c];
        xA[c] = m_exp[0][c];  xB[c] = m_exp[1][c];
        bA = bA | (since[0][c] >= 0); bB = bB | (since[1][c] >= 0);
      end
      total++; if (showA !== eA || showB !== eB) begin bad++; $display("FAIL rand_show n=%0d got=%h/%h want=%h/%h", n, showA, showB, eA, eB); end
      total++; if (expA !== xA || expB !== xB) begin bad++; $display("FAIL rand_expired n=%0d got=%h/%h want=%h/%h", n, expA, expB, xA, xB); end
      total++; if (busyA !== bA || busyB !== bB) begin bad++; $display("FAIL rand_busy n=%0d got=%b%b want=%b%b", n, busyA, busyB, bA, bB); end
    end
    hitA = '0; hitB = '0; sof = 1'b0; freeze = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    hitA = 6'b100000; hitB = 6'b100000; @(negedge clk); hitA = '0; hitB = '0;
    repeat (2) sof_pulse();
    #2 resetN = 1'b0;
    #1;
    total++; if (showA !== 6'h3F || showB !== 6'h3F) begin bad++; $display("FAIL midreset_show got=%h/%h want=3f", showA, showB); end
    total++; if (busyA !== 1'b0 || expA !== '0) begin bad++; $display("FAIL midreset_busy_exp got=%b/%h want=0/0", busyA, expA); end
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (expA !== '0 || busyA !== 1'b0) begin bad++; $display("FAIL midreset_after got=%h/%b want=0/0", expA, busyA); end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_placement();
    test_timeout();
    test_retrigger();
    test_freeze();
    test_blink();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
